bcd_decoder: RTL and testbench

Sequential BCD-to-binary converter and the inverse of the `bcd_encoder` block. It continuously samples a packed BCD word and converts it MSD-first, one digit per clock, using Horner accumulation (acc = acc·10 + digit). It publishes the binary result with a one-cycle ready pulse. It sits on the receive side of any path carrying packed BCD, and closes the loop for encoder/decoder round-trip checks.

---
 rtl/bcd_decoder.sv | 140 ++++++++++++++
 tb/tb_bcd_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_decoder.sv
// bcd_decoder: sequential packed-BCD to binary converter.
//
// The block runs without a start input. It samples BCD_data once per period and
// converts it most-significant digit first, one digit per clock, with Horner
// accumulation (acc = acc*10 + digit). It then publishes the result with a
// one-cycle ready pulse. A period is DECIMAL_LENGTH+2 cycles: LOAD, then
// DECIMAL_LENGTH CONVERT cycles, then DONE.
//
// Parameters:
//   BINARY_LENGTH  - width of the binary result
//   DECIMAL_LENGTH - number of BCD digits in BCD_data
// Ports:
//   CLK          - clock, rising edge
//   RST          - asynchronous active-high reset
//   BCD_data     - packed BCD input; digit 0 (most significant) is in the top nibble
//   binary_data  - last valid converted value; held when a conversion fails
//   binary_ready - one-cycle pulse per completed conversion
//   binary_error - 1 if the most recent conversion had a nibble > 9 or overflowed
module bcd_decoder #(
  parameter int unsigned BINARY_LENGTH  = 7,
  parameter int unsigned DECIMAL_LENGTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [4*DECIMAL_LENGTH-1:0] BCD_data,
  output logic [BINARY_LENGTH-1:0]    binary_data,
  output logic                        binary_ready,
  output logic                        binary_error
);

  localparam int unsigned InW  = 4 * DECIMAL_LENGTH;
  // One spare bit above the input width. The largest value reachable even with
  // all-0xF digits is 15*(10^N-1)/9, and that stays below 2^(4N+1). So acc*10+d
  // never wraps.
  localparam int unsigned AccW = InW + 1;
  localparam int unsigned CntW = $clog2(DECIMAL_LENGTH) + 1;
  // Zero-extended view of acc. It lets the result slice and the overflow test
  // work for any BINARY_LENGTH, including one wider than the accumulator.
  localparam int unsigned ExtW = AccW + BINARY_LENGTH;

  localparam logic [CntW-1:0] LastDigit = CntW'(DECIMAL_LENGTH - 1);

  typedef enum logic [1:0] {
    StLoad,
    StConvert,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [InW-1:0]  shift_q, shift_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            invalid_q, invalid_d;

  logic [BINARY_LENGTH-1:0] data_d;
  logic                     ready_d;
  logic                     error_d;

  logic [3:0]      digit;
  logic [ExtW-1:0] acc_ext;
  logic            overflow;

  assign digit    = shift_q[InW-1 -: 4];
  assign acc_ext  = ExtW'(acc_q);
  // Any bit set at or above BINARY_LENGTH means acc > 2^BINARY_LENGTH - 1.
  assign overflow = (acc_ext >> BINARY_LENGTH) != '0;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    invalid_d = invalid_q;
    data_d    = binary_data;
    ready_d   = 1'b0;
    error_d   = binary_error;

    case (state_q)
      StLoad: begin
        shift_d   = BCD_data;
        acc_d     = '0;
        cnt_d     = '0;
        invalid_d = 1'b0;
        state_d   = StConvert;
      end

      StConvert: begin
        // acc*10 = acc*8 + acc*2. Illegal digits are still accumulated; the
        // sticky flag is what rejects the word.
        acc_d   = (acc_q << 3) + (acc_q << 1) + AccW'(digit);
        if (digit > 4'd9) begin
          invalid_d = 1'b1;
        end
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastDigit) begin
          state_d = StDone;
        end
      end

      StDone: begin
        ready_d = 1'b1;
        if (!invalid_q && !overflow) begin
          data_d  = acc_ext[BINARY_LENGTH-1:0];
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
        state_d = StLoad;
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StLoad;
      shift_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      invalid_q    <= 1'b0;
      binary_data  <= '0;
      binary_ready <= 1'b0;
      binary_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      invalid_q    <= invalid_d;
      binary_data  <= data_d;
      binary_ready <= ready_d;
      binary_error <= error_d;
    end
  end

endmodule

// File: tb/tb_bcd_decoder.sv
// Testbench for bcd_decoder at default parameters (7-bit result, 4 digits).
// A reference model turns each driven BCD word into the expected data and error
// values. These go into a queue, which is popped when the next ready pulse appears.
module tb_bcd_decoder;

  logic        CLK;
  logic        RST;
  logic [15:0] BCD_data;
  logic [6:0]  binary_data;
  logic        binary_ready;
  logic        binary_error;

  int total;
  int bad;
  int prev_valid;
  int q_data[$];
  int q_err[$];

  bcd_decoder #(
    .BINARY_LENGTH (7),
    .DECIMAL_LENGTH(4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BCD_data    (BCD_data),
    .binary_data (binary_data),
    .binary_ready(binary_ready),
    .binary_error(binary_error)
  );

  initial CLK = 1'b0;
  always #31 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference conversion of one packed word, pushed to the scoreboard.
  task automatic push_exp(input logic [15:0] w);
    int  v;
    bit  inv;
    logic [3:0] nib;
    v   = 0;
    inv = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      nib = w[i*4 +: 4];
      if (nib > 4'd9) inv = 1'b1;
      v = v * 10 + int'(nib);
    end
    if (inv || v > 127) begin
      q_data.push_back(prev_valid);
      q_err.push_back(1);
    end else begin
      prev_valid = v;
      q_data.push_back(v);
      q_err.push_back(0);
    end
  endtask

  // Independent binary -> packed BCD encoder used for the loopback step.
  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Wait (bounded) for the next ready pulse and check its position and payload.
  task automatic expect_pulse(input string tag, input int exp_gap);
    int gap;
    bit seen;
    int d;
    int e;
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      gap++;
      if (binary_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) gap = -1;
    chk({tag, "_gap"}, gap, exp_gap);
    d = q_data.pop_front();
    e = q_err.pop_front();
    chk({tag, "_data"}, int'(binary_data), d);
    chk({tag, "_err"}, int'(binary_error), e);
  endtask

  task automatic step(input string tag, input logic [15:0] w);
    BCD_data = w;
    push_exp(w);
    expect_pulse(tag, 6);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    prev_valid = 0;
    RST        = 1'b1;
    BCD_data   = 16'h0054;

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_data", int'(binary_data), 0);
    chk("rst_ready", int'(binary_ready), 0);
    chk("rst_err", int'(binary_error), 0);

    @(negedge CLK);
    RST = 1'b0;
    push_exp(16'h0054);
    expect_pulse("first", 6);

    tick();
    chk("ready_one_cycle", int'(binary_ready), 0);
    chk("data_stable", int'(binary_data), 54);
    push_exp(16'h0054);
    expect_pulse("repeat", 5);

    // Change during CONVERT: the running period still reports 54.
    tick();
    tick();
    BCD_data = 16'h0122;
    push_exp(16'h0054);
    expect_pulse("mid_old", 4);
    push_exp(16'h0122);
    expect_pulse("mid_new", 6);

    step("max_ok", 16'h0127);
    step("ovf", 16'h0128);
    step("ovf_clear", 16'h0023);
    step("bad_digit", 16'h00A3);
    step("zero", 16'h0000);
    step("big_ovf", 16'h9999);
    step("pre_rst", 16'h0099);

    // Reset while the third digit is being converted.
    BCD_data = 16'h0045;
    repeat (3) tick();
    RST = 1'b1;
    #1;
    chk("midrst_data", int'(binary_data), 0);
    chk("midrst_ready", int'(binary_ready), 0);
    chk("midrst_err", int'(binary_error), 0);
    prev_valid = 0;
    @(negedge CLK);
    RST = 1'b0;
    push_exp(16'h0045);
    expect_pulse("after_rst", 6);

    step("loop_54", bin2bcd(54));
    step("loop_122", bin2bcd(122));
    step("loop_23", bin2bcd(23));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
